store_merge_unit: RTL and testbench

- Store-path counterpart of the load-side immediate/data extender: it narrows a 32-bit register value to byte or halfword width and writes it into a word-only data RAM, which has no byte enables.
- Sub-word stores (sb/sh) run as read-modify-write sequences. Word stores (sw) are direct writes.
- Sits between the MEM stage and the data RAM. The pipeline stalls on busy.

---
 rtl/store_merge_pkg.sv | 23 ++
 rtl/store_lane_merge.sv | 35 +++
 rtl/store_merge_unit.sv | 123 ++++++++++++
 tb/tb_store_merge_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_merge_pkg.sv
// Shared definitions for the store merge unit: op encodings, FSM states
// and the byte-lane mapping used by the read-modify-write path.
package store_merge_pkg;

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SH = 2'b01;
    localparam logic [1:0] OP_SB = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR,
        S_FIN,
        S_ERR
    } state_t;

    // Byte lane inside the 32-bit word addressed by the low address bits.
    function automatic logic [1:0] lane_of(input logic [1:0] addr, input logic big_endian);
        return big_endian ? (2'd3 - addr) : addr;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: replaces the byte or halfword selected by the
// store address inside the old RAM word. Word stores pass wdata through.
module store_lane_merge
    import store_merge_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  op,
    input  logic [1:0]  addr,
    input  logic        big_endian,
    output logic [31:0] merged
);

    logic [1:0] lane;

    // Overlay the narrowed store data onto the old word at its lane.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        lane   = lane_of(addr, big_endian);
        merged = wdata;
        case (op)
            OP_SB: begin
                merged = old_word;
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            OP_SH: begin
                // For an aligned halfword lane[1] already reflects the endian swap.
                merged = old_word;
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store path between MEM stage and a word-only data RAM. Word stores are
// written directly; byte/halfword stores run a read-modify-write sequence.
module store_merge_unit
    import store_merge_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata
);

    state_t      state, next_state;
    logic [1:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [1:0]  wait_cnt;
    logic        accept;
    logic        bad_align;
    logic [1:0]  m_op;
    logic [1:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] merged;

    assign accept    = (state == S_IDLE) && req;
    assign bad_align = (op == 2'b11)
                    || ((op == OP_SH) && addr[0])
                    || ((op == OP_SW) && (addr[1:0] != 2'b00));

    // A word store goes straight from IDLE to WR, so the merge sees the live
    // request in that cycle and the captured request afterwards.
    assign m_op    = accept ? op        : op_q;
    assign m_addr  = accept ? addr[1:0] : addr_lo_q;
    assign m_wdata = accept ? wdata     : wdata_q;

    store_lane_merge u_merge (
        .old_word   (mem_rdata),
        .wdata      (m_wdata),
        .op         (m_op),
        .addr       (m_addr),
        .big_endian (BIG_ENDIAN),
        .merged     (merged)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates together at the edge.
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (bad_align)        next_state = S_ERR;
                    else if (op == OP_SW) next_state = S_WR;
                    else                  next_state = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: next_state = S_RD_WAIT;
            S_RD_WAIT:  if (wait_cnt == 2'd0) next_state = S_WR;
            S_WR:       next_state = S_FIN;
            S_FIN:      next_state = S_IDLE;
            S_ERR:      next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Request capture and read-latency countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_SW;
            addr_lo_q <= 2'b00;
            wdata_q   <= '0;
            wait_cnt  <= 2'd0;
        end else begin
            if (accept) begin
                op_q      <= op;
                addr_lo_q <= addr[1:0];
                wdata_q   <= wdata;
            end
            if (state == S_RD_ISSUE)     wait_cnt <= 2'(RD_LATENCY - 1);
            else if (state == S_RD_WAIT) wait_cnt <= wait_cnt - 2'd1;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            misalign  <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            busy     <= (next_state != S_IDLE);
            done     <= (next_state == S_FIN) || (next_state == S_ERR);
            misalign <= (next_state == S_ERR);
            mem_re   <= (next_state == S_RD_ISSUE);
            mem_we   <= (next_state == S_WR);
            if (accept)               mem_addr  <= {addr[31:2], 2'b00};
            if (next_state == S_WR)   mem_wdata <= merged;
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: two instances (little-endian latency 1 and
// big-endian latency 3) share the request inputs; each has its own RAM read
// model and activity monitor. Expected words come from a byte-array model.
module tb_store_merge_unit;

    localparam logic [1:0] SW  = 2'b00;
    localparam logic [1:0] SH  = 2'b01;
    localparam logic [1:0] SB  = 2'b10;
    localparam logic [1:0] RSV = 2'b11;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam bit BE0  = 1'b0;
    localparam bit BE1  = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        busy [2];
    logic        done [2];
    logic        misalign [2];
    logic        mem_re [2];
    logic        mem_we [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_rdata [2];
    logic [31:0] mem_wdata [2];

    logic [31:0] ram_val [2];
    logic        rd_vld [2][3];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    int re_cnt [2]        = '{0, 0};
    int we_cnt [2]        = '{0, 0};
    int done_cnt [2]      = '{0, 0};
    int busy_cnt [2]      = '{0, 0};
    int overlap_cnt [2]   = '{0, 0};
    int busy_tail_bad [2] = '{0, 0};
    int done_cyc [2]      = '{0, 0};
    logic        done_mis [2];
    logic        prev_done [2];
    logic [31:0] we_addr [2];
    logic [31:0] we_data [2];
    logic [31:0] re_addr [2];

    always #5 clk = ~clk;

    store_merge_unit #(.RD_LATENCY(LAT0), .BIG_ENDIAN(BE0)) dut_le (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy[0]), .done(done[0]), .misalign(misalign[0]),
        .mem_addr(mem_addr[0]), .mem_re(mem_re[0]), .mem_rdata(mem_rdata[0]),
        .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0])
    );

    store_merge_unit #(.RD_LATENCY(LAT1), .BIG_ENDIAN(BE1)) dut_be (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy[1]), .done(done[1]), .misalign(misalign[1]),
        .mem_addr(mem_addr[1]), .mem_re(mem_re[1]), .mem_rdata(mem_rdata[1]),
        .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1])
    );

    // RAM read model: data is valid only in the cycle RD_LATENCY after mem_re.
    assign mem_rdata[0] = rd_vld[0][LAT0-1] ? ram_val[0] : 32'hBAD0_BAD0;
    assign mem_rdata[1] = rd_vld[1][LAT1-1] ? ram_val[1] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            rd_vld[k][0] <= mem_re[k];
            rd_vld[k][1] <= rd_vld[k][0];
            rd_vld[k][2] <= rd_vld[k][1];
        end
    end

    // Activity monitor sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_re[k]) begin
                re_cnt[k]  <= re_cnt[k] + 1;
                re_addr[k] <= mem_addr[k];
            end
            if (mem_we[k]) begin
                we_cnt[k]  <= we_cnt[k] + 1;
                we_addr[k] <= mem_addr[k];
                we_data[k] <= mem_wdata[k];
            end
            if (mem_re[k] && mem_we[k]) overlap_cnt[k] <= overlap_cnt[k] + 1;
            if (busy[k]) busy_cnt[k] <= busy_cnt[k] + 1;
            if (done[k]) begin
                done_cnt[k] <= done_cnt[k] + 1;
                done_cyc[k] <= cyc;
                done_mis[k] <= misalign[k];
            end
            if (prev_done[k] === 1'b1 && busy[k] === 1'b1) busy_tail_bad[k] <= busy_tail_bad[k] + 1;
            prev_done[k] <= done[k];
        end
    end

    // Reference: store rules expressed on a 4-byte array.
    function automatic bit is_bad(input logic [1:0] o, input logic [31:0] a);
        return (o == RSV) || (o == SH && a[0]) || (o == SW && a[1:0] != 2'b00);
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input int lat);
        if (is_bad(o, a)) return 1;
        if (o == SW) return 2;
        return lat + 3;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] old, input logic [1:0] o,
                                             input logic [31:0] a, input logic [31:0] wd,
                                             input bit be);
        logic [7:0]  b [4];
        logic [31:0] w;
        int          pos;
        int          half;
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        if (o == SB) begin
            pos = be ? 3 - int'(a[1:0]) : int'(a[1:0]);
            b[pos] = wd[7:0];
        end else if (o == SH) begin
            half = be ? 1 - int'(a[1]) : int'(a[1]);
            b[2*half]     = wd[7:0];
            b[2*half + 1] = wd[15:8];
        end
        w = {b[3], b[2], b[1], b[0]};
        if (o == SW) w = wd;
        return w;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One store on both instances, then every observable is compared.
    task automatic run_store(input logic [1:0] o, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] r0, input logic [31:0] r1, input string tag);
        int re0 [2], we0 [2], dn0 [2], bz0 [2], ov0 [2];
        int lat [2];
        bit be [2];
        int acc;
        bit bad;
        logic [31:0] exp_w;
        lat = '{LAT0, LAT1};
        be  = '{BE0, BE1};
        bad = is_bad(o, a);
        ram_val[0] = r0;
        ram_val[1] = r1;
        for (int k = 0; k < 2; k++) begin
            re0[k] = re_cnt[k]; we0[k] = we_cnt[k]; dn0[k] = done_cnt[k];
            bz0[k] = busy_cnt[k]; ov0[k] = overlap_cnt[k];
        end
        op = o; addr = a; wdata = wd; req = 1'b1;
        acc = cyc;
        step();
        req = 1'b0;
        for (int n = 0; n < 20 && (done_cnt[0] == dn0[0] || done_cnt[1] == dn0[1]); n++) step();
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            exp_w = ref_word((k == 0) ? r0 : r1, o, a, wd, be[k]);
            checks++;
            if (done_cnt[k] - dn0[k] !== 1) begin
                failures++;
                $display("FAIL %s dut%0d done_pulses got=%0d exp=1", tag, k, done_cnt[k] - dn0[k]);
            end
            checks++;
            if (done_cyc[k] - acc !== exp_lat(o, a, lat[k])) begin
                failures++;
                $display("FAIL %s dut%0d latency got=%0d exp=%0d", tag, k, done_cyc[k] - acc, exp_lat(o, a, lat[k]));
            end
            checks++;
            if (done_mis[k] !== bad) begin
                failures++;
                $display("FAIL %s dut%0d misalign got=%b exp=%b", tag, k, done_mis[k], bad);
            end
            checks++;
            if (re_cnt[k] - re0[k] !== ((bad || o == SW) ? 0 : 1)) begin
                failures++;
                $display("FAIL %s dut%0d mem_re_count got=%0d exp=%0d", tag, k, re_cnt[k] - re0[k], (bad || o == SW) ? 0 : 1);
            end
            checks++;
            if (we_cnt[k] - we0[k] !== (bad ? 0 : 1)) begin
                failures++;
                $display("FAIL %s dut%0d mem_we_count got=%0d exp=%0d", tag, k, we_cnt[k] - we0[k], bad ? 0 : 1);
            end
            checks++;
            if (busy_cnt[k] - bz0[k] !== exp_lat(o, a, lat[k])) begin
                failures++;
                $display("FAIL %s dut%0d busy_cycles got=%0d exp=%0d", tag, k, busy_cnt[k] - bz0[k], exp_lat(o, a, lat[k]));
            end
            checks++;
            if (overlap_cnt[k] - ov0[k] !== 0) begin
                failures++;
                $display("FAIL %s dut%0d re_we_overlap got=%0d exp=0", tag, k, overlap_cnt[k] - ov0[k]);
            end
            if (!bad) begin
                checks++;
                if (we_addr[k] !== {a[31:2], 2'b00}) begin
                    failures++;
                    $display("FAIL %s dut%0d mem_addr got=%h exp=%h", tag, k, we_addr[k], {a[31:2], 2'b00});
                end
                checks++;
                if (we_data[k] !== exp_w) begin
                    failures++;
                    $display("FAIL %s dut%0d mem_wdata got=%h exp=%h", tag, k, we_data[k], exp_w);
                end
                if (o != SW) begin
                    checks++;
                    if (re_addr[k] !== we_addr[k]) begin
                        failures++;
                        $display("FAIL %s dut%0d addr_stable rd=%h wr=%h", tag, k, re_addr[k], we_addr[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({busy[k], done[k], misalign[k], mem_re[k], mem_we[k], mem_addr[k], mem_wdata[k]} !== '0) begin
                failures++;
                $display("FAIL reset dut%0d outputs busy=%b done=%b mis=%b re=%b we=%b addr=%h wdata=%h exp=all_zero",
                         k, busy[k], done[k], misalign[k], mem_re[k], mem_we[k], mem_addr[k], mem_wdata[k]);
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        run_store(SW, 32'h0000_0100, 32'hDEAD_BEEF, 32'h5555_5555, 32'h5555_5555, "sw_basic");
        run_store(SB, 32'h0000_0203, 32'h1234_56AB, 32'h1122_3344, 32'h1122_3344, "sb_lane3");
        run_store(SH, 32'h0000_0202, 32'hFFFF_CAFE, 32'h1122_3344, 32'h1122_3344, "sh_half1");
        run_store(SH, 32'h0000_0200, 32'h0000_BEEF, 32'hA1B2_C3D4, 32'hA1B2_C3D4, "sh_half0");
        run_store(SB, 32'h0000_0200, 32'hFFFF_FF5A, 32'h0102_0304, 32'h0102_0304, "sb_lane0");
    endtask

    task automatic test_misalign();
        run_store(SH, 32'h0000_0201, 32'h0000_1234, 32'h0, 32'h0, "sh_odd");
        run_store(SW, 32'h0000_0302, 32'h0000_1234, 32'h0, 32'h0, "sw_off2");
        run_store(RSV, 32'h0000_0300, 32'h0000_1234, 32'h0, 32'h0, "op_reserved");
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            run_store(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom, "random");
        end
    endtask

    // req held high: the latency-3 instance performs one store and re-accepts
    // only in the cycle after FIN.
    task automatic test_back_to_back();
        int acc, re0, we0;
        re0 = re_cnt[1];
        we0 = we_cnt[1];
        ram_val[0] = 32'h8899_AABB;
        ram_val[1] = 32'h8899_AABB;
        op = SB; addr = 32'h0000_0041; wdata = 32'h0000_00C3; req = 1'b1;
        acc = cyc;
        repeat (6) step();
        checks++;
        if (done[1] !== 1'b1 || done_cyc[1] - acc !== 6) begin
            failures++;
            $display("FAIL hold_req done got=%b at=%0d exp=1 at=6", done[1], done_cyc[1] - acc);
        end
        checks++;
        if (we_cnt[1] - we0 !== 1) begin
            failures++;
            $display("FAIL hold_req single_write got=%0d exp=1", we_cnt[1] - we0);
        end
        checks++;
        if (we_data[1] !== ref_word(32'h8899_AABB, SB, 32'h0000_0041, 32'h0000_00C3, BE1)) begin
            failures++;
            $display("FAIL hold_req wdata got=%h exp=%h", we_data[1], ref_word(32'h8899_AABB, SB, 32'h0000_0041, 32'h0000_00C3, BE1));
        end
        step();
        checks++;
        if (busy[1] !== 1'b0 || re_cnt[1] - re0 !== 1) begin
            failures++;
            $display("FAIL hold_req idle_gap busy=%b reads=%0d exp busy=0 reads=1", busy[1], re_cnt[1] - re0);
        end
        step();
        checks++;
        if (busy[1] !== 1'b1 || mem_re[1] !== 1'b1 || re_cnt[1] - re0 !== 2) begin
            failures++;
            $display("FAIL hold_req second_accept busy=%b re=%b reads=%0d exp 1 1 2", busy[1], mem_re[1], re_cnt[1] - re0);
        end
        req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        int we0 [2], dn0 [2];
        for (int k = 0; k < 2; k++) begin
            we0[k] = we_cnt[k];
            dn0[k] = done_cnt[k];
        end
        ram_val[0] = 32'hCAFE_F00D;
        ram_val[1] = 32'hCAFE_F00D;
        op = SB; addr = 32'h0000_0083; wdata = 32'h0000_0077; req = 1'b1;
        step();
        req = 1'b0;
        step();
        rst = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({busy[k], done[k], misalign[k], mem_re[k], mem_we[k], mem_addr[k], mem_wdata[k]} !== '0) begin
                failures++;
                $display("FAIL reset_mid dut%0d outputs busy=%b done=%b mis=%b re=%b we=%b addr=%h wdata=%h exp=all_zero",
                         k, busy[k], done[k], misalign[k], mem_re[k], mem_we[k], mem_addr[k], mem_wdata[k]);
            end
        end
        rst = 1'b0;
        repeat (8) step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (we_cnt[k] - we0[k] !== 0 || done_cnt[k] - dn0[k] !== 0) begin
                failures++;
                $display("FAIL reset_mid dut%0d abandoned writes=%0d dones=%0d exp 0 0", k, we_cnt[k] - we0[k], done_cnt[k] - dn0[k]);
            end
        end
        run_store(SB, 32'h0000_0083, 32'h0000_0077, 32'hCAFE_F00D, 32'hCAFE_F00D, "after_reset");
    endtask

    task automatic test_invariants();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy_tail_bad[k] !== 0 || overlap_cnt[k] !== 0) begin
                failures++;
                $display("FAIL invariants dut%0d busy_after_done=%0d re_we_overlap=%0d exp 0 0", k, busy_tail_bad[k], overlap_cnt[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; op = SW; addr = '0; wdata = '0;
        ram_val[0] = '0; ram_val[1] = '0;
        test_reset();
        test_directed();
        test_misalign();
        test_random(40);
        test_back_to_back();
        test_reset_mid();
        test_random(10);
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
